// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if
//   Bundles the W-stage request, the MDU valid/ready request and the
//   registered GRF write port shared by the arbiter and its neighbours.
//   slave  : arbiter view (requests in; stall, ready and GRF write out).
//   master : requester/GRF view (requests out; stall, ready and GRF write in).
//   W stage : p_we, p_a3[4:0], p_wd[31:0], p_pc[31:0], p_stall
//   MDU     : m_valid, m_a3[4:0], m_wd[31:0], m_pc[31:0], m_ready
//   GRF     : grf_we, grf_a3[4:0], grf_wd[31:0], grf_pc[31:0]
interface grf_wb_arbiter_if;
  logic        p_we;
  logic [4:0]  p_a3;
  logic [31:0] p_wd;
  logic [31:0] p_pc;
  logic        p_stall;

  logic        m_valid;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [31:0] m_pc;
  logic        m_ready;

  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  modport slave (
    input  p_we, p_a3, p_wd, p_pc, m_valid, m_a3, m_wd, m_pc,
    output p_stall, m_ready, grf_we, grf_a3, grf_wd, grf_pc
  );

  modport master (
    output p_we, p_a3, p_wd, p_pc, m_valid, m_a3, m_wd, m_pc,
    input  p_stall, m_ready, grf_we, grf_a3, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
//   Shares the single GRF write port between the pipeline W stage (fixed
//   priority) and the multiply/divide unit (valid/ready). A starvation
//   counter forces one stall cycle so a waiting MDU write always lands.
//   Writes to $0 are never forwarded to the GRF.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : grf_wb_arbiter_if.slave (W stage, MDU and GRF write signals)
// Parameters:
//   STARVE_LIMIT : consecutive denied MDU cycles before a forced grant (1..15)
//   CNT_W        : starvation counter width, must hold STARVE_LIMIT
// Build option:
//   GRF_WB_TRACE_EN : when defined, prints one line per committed GRF write.
module grf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input logic              clk,
  input logic              reset,
  grf_wb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;

  logic               r_p_stall;
  logic               r_grf_we;
  logic [4:0]         r_grf_a3;
  logic [31:0]        r_grf_wd;
  logic [31:0]        r_grf_pc;

  logic               w_p_req;
  logic               w_p_grant;
  logic               w_m_ready;
  logic               w_m_write;
  logic               w_m_deny;
  logic               w_write;
  logic [4:0]         w_win_a3;
  logic [31:0]        w_win_wd;
  logic [31:0]        w_win_pc;

  // Grant decision. An MDU write to $0 is accepted at once even alongside
  // a P write, since it never needs the port.
  always_comb begin
    w_p_req   = bus.p_we && (bus.p_a3 != '0);
    w_p_grant = 1'b0;
    w_m_ready = 1'b0;
    if (r_state == FORCE) begin
      w_m_ready = bus.m_valid;
    end else if (bus.m_valid && (bus.m_a3 == '0)) begin
      w_m_ready = 1'b1;
      w_p_grant = w_p_req;
    end else if (w_p_req) begin
      w_p_grant = 1'b1;
    end else begin
      w_m_ready = bus.m_valid;
    end
    w_m_write = w_m_ready && (bus.m_a3 != '0);
    w_m_deny  = bus.m_valid && !w_m_ready;
    w_write   = w_p_grant || w_m_write;

    w_win_a3  = w_p_grant ? bus.p_a3 : bus.m_a3;
    w_win_wd  = w_p_grant ? bus.p_wd : bus.m_wd;
    w_win_pc  = w_p_grant ? bus.p_pc : bus.m_pc;
  end

  // Next state and counter. Any cycle without a denial (granted or no
  // request) clears the count, so FORCE always exits to IDLE.
  always_comb begin
    w_cnt_inc   = r_cnt + CNT_W'(1);
    w_cnt_nxt   = '0;
    w_state_nxt = IDLE;
    if (w_m_deny) begin
      w_cnt_nxt   = w_cnt_inc;
      w_state_nxt = (w_cnt_inc == CNT_W'(STARVE_LIMIT)) ? FORCE : WAIT;
    end
  end

  // p_stall is registered from the next state so it is high exactly
  // while the FSM sits in FORCE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_p_stall <= 1'b0;
      r_grf_we  <= 1'b0;
      r_grf_a3  <= '0;
      r_grf_wd  <= '0;
      r_grf_pc  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_p_stall <= (w_state_nxt == FORCE);
      r_grf_we  <= w_write;
      if (w_write) begin
        r_grf_a3 <= w_win_a3;
        r_grf_wd <= w_win_wd;
        r_grf_pc <= w_win_pc;
      end
    end
  end

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && w_write) begin
      $display("%d@%h: $%d <= %h", $time, w_win_pc, w_win_a3, w_win_wd);
    end
  end
`endif

  // m_ready is combinational; gate it so it is low during reset.
  assign bus.m_ready = w_m_ready && reset;
  assign bus.p_stall = r_p_stall;
  assign bus.grf_we  = r_grf_we;
  assign bus.grf_a3  = r_grf_a3;
  assign bus.grf_wd  = r_grf_wd;
  assign bus.grf_pc  = r_grf_pc;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter
//   Self-checking bench for grf_wb_arbiter (STARVE_LIMIT=4). Expected GRF
//   writes are queued as stimulus is driven and compared by a monitor after
//   each rising edge; handshake and reset behaviour is checked inline.
module tb_grf_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  wr_t  exp_q[$];

  grf_wb_arbiter_if bus();

  grf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    wr_t e;
    e.a3 = a3;
    e.wd = wd;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.p_we = 1'b0; bus.p_a3 = '0; bus.p_wd = '0; bus.p_pc = '0;
    bus.m_valid = 1'b0; bus.m_a3 = '0; bus.m_wd = '0; bus.m_pc = '0;
  endtask

  // Scoreboard monitor: every committed write must match the oldest entry.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.grf_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got a3=%0d wd=%h pc=%h, wanted no write",
                   bus.grf_a3, bus.grf_wd, bus.grf_pc);
        end else begin
          e = exp_q.pop_front();
          if ({bus.grf_a3, bus.grf_wd, bus.grf_pc} !== {e.a3, e.wd, e.pc}) begin
            n_bad++;
            $display("FAIL grf_write: got a3=%0d wd=%h pc=%h, wanted a3=%0d wd=%h pc=%h",
                     bus.grf_a3, bus.grf_wd, bus.grf_pc, e.a3, e.wd, e.pc);
          end
        end
      end
    end
  end

  task automatic test_reset();
    bus.m_valid = 1'b1; bus.m_a3 = 5'd7; bus.m_wd = 32'h77; bus.m_pc = 32'h700;
    #12;
    n_cmp++;
    if ({bus.p_stall, bus.m_ready, bus.grf_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got stall/ready/we=%b, wanted 000",
               {bus.p_stall, bus.m_ready, bus.grf_we});
    end
    n_cmp++;
    if ({bus.grf_a3, bus.grf_wd, bus.grf_pc} !== 69'd0) begin
      n_bad++;
      $display("FAIL reset_data: got a3=%0d wd=%h pc=%h, wanted all zero",
               bus.grf_a3, bus.grf_wd, bus.grf_pc);
    end
    idle_inputs();
    tick();
    reset = 1'b1;
    bus.p_we = 1'b1; bus.p_a3 = 5'd6; bus.p_wd = 32'h66; bus.p_pc = 32'h1000;
    push_wr(5'd6, 32'h66, 32'h1000);
    tick();
    bus.p_we = 1'b0;
    bus.m_valid = 1'b1; bus.m_a3 = 5'd7;
    #1;
    n_cmp++;
    if (bus.m_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_ready: got %b, wanted 1", bus.m_ready);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.p_stall, bus.m_ready, bus.grf_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset: got stall/ready/we=%b, wanted 000",
               {bus.p_stall, bus.m_ready, bus.grf_we});
    end
    idle_inputs();
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.grf_we !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_release: got we=%b pending=%0d, wanted we=0 pending=0",
               bus.grf_we, exp_q.size());
    end
  endtask

  task automatic test_p_only();
    bus.p_we = 1'b1; bus.p_a3 = 5'd5; bus.p_wd = 32'h0000_1234; bus.p_pc = 32'h0000_3000;
    push_wr(5'd5, 32'h0000_1234, 32'h0000_3000);
    #1;
    n_cmp++;
    if ({bus.p_stall, bus.m_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL p_only_ctrl: got stall/ready=%b, wanted 00", {bus.p_stall, bus.m_ready});
    end
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (bus.grf_we !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL p_only_done: got we=%b pending=%0d, wanted we=0 pending=0",
               bus.grf_we, exp_q.size());
    end
  endtask

  task automatic test_m_only();
    bus.m_valid = 1'b1; bus.m_a3 = 5'd8; bus.m_wd = 32'hDEAD_BEEF; bus.m_pc = 32'h0000_4000;
    #1;
    n_cmp++;
    if (bus.m_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL m_only_ready: got %b, wanted 1", bus.m_ready);
    end
    push_wr(5'd8, 32'hDEAD_BEEF, 32'h0000_4000);
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL m_only_done: got pending=%0d, wanted 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    bus.p_we = 1'b1; bus.p_a3 = 5'd2;
    bus.m_valid = 1'b1; bus.m_a3 = 5'd9; bus.m_wd = 32'hCAFE_0009; bus.m_pc = 32'h0000_5000;
    for (int c = 0; c < int'(LIMIT); c++) begin
      bus.p_wd = 32'h200 + 32'(c);
      bus.p_pc = 32'h3000 + 32'(4 * c);
      push_wr(5'd2, bus.p_wd, bus.p_pc);
      #1;
      n_cmp++;
      if ({bus.p_stall, bus.m_ready} !== 2'b00) begin
        n_bad++;
        $display("FAIL contend_deny cyc%0d: got stall/ready=%b, wanted 00",
                 c, {bus.p_stall, bus.m_ready});
      end
      tick();
    end
    bus.p_wd = 32'h204; bus.p_pc = 32'h3010;
    #1;
    n_cmp++;
    if ({bus.p_stall, bus.m_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL contend_force: got stall/ready=%b, wanted 11", {bus.p_stall, bus.m_ready});
    end
    push_wr(5'd9, 32'hCAFE_0009, 32'h0000_5000);
    tick();
    bus.m_valid = 1'b0;
    push_wr(5'd2, 32'h204, 32'h3010);
    #1;
    n_cmp++;
    if ({bus.p_stall, bus.m_ready, bus.grf_a3} !== {2'b00, 5'd9}) begin
      n_bad++;
      $display("FAIL contend_after: got stall/ready=%b a3=%0d, wanted 00 a3=9",
               {bus.p_stall, bus.m_ready}, bus.grf_a3);
    end
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL contend_done: got pending=%0d, wanted 0", exp_q.size());
    end
  endtask

  task automatic test_zero();
    bus.p_we = 1'b1; bus.p_a3 = 5'd0; bus.p_wd = 32'h0BAD; bus.p_pc = 32'h0BAD;
    bus.m_valid = 1'b1; bus.m_a3 = 5'd3; bus.m_wd = 32'h3333; bus.m_pc = 32'h7000;
    #1;
    n_cmp++;
    if (bus.m_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL p_zero_ready: got %b, wanted 1", bus.m_ready);
    end
    push_wr(5'd3, 32'h3333, 32'h7000);
    tick();
    bus.p_a3 = 5'd4; bus.p_wd = 32'h4444; bus.p_pc = 32'h7004;
    bus.m_a3 = 5'd0; bus.m_wd = 32'h0BAD; bus.m_pc = 32'h0BAD;
    #1;
    n_cmp++;
    if (bus.m_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL m_zero_ready: got %b, wanted 1", bus.m_ready);
    end
    push_wr(5'd4, 32'h4444, 32'h7004);
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (bus.grf_we !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL zero_done: got we=%b pending=%0d, wanted we=0 pending=0",
               bus.grf_we, exp_q.size());
    end
  endtask

  task automatic test_reset_force();
    bit got;
    int waited;
    bus.p_we = 1'b1; bus.p_a3 = 5'd2;
    bus.m_valid = 1'b1; bus.m_a3 = 5'd9; bus.m_wd = 32'h9999; bus.m_pc = 32'h8000;
    for (int c = 0; c < int'(LIMIT); c++) begin
      bus.p_wd = 32'h500 + 32'(c);
      bus.p_pc = 32'h8100 + 32'(4 * c);
      push_wr(5'd2, bus.p_wd, bus.p_pc);
      tick();
    end
    #1;
    n_cmp++;
    if ({bus.p_stall, bus.m_ready, bus.grf_we} !== 3'b111) begin
      n_bad++;
      $display("FAIL rf_force: got stall/ready/we=%b, wanted 111",
               {bus.p_stall, bus.m_ready, bus.grf_we});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.p_stall, bus.m_ready, bus.grf_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL rf_reset: got stall/ready/we=%b, wanted 000",
               {bus.p_stall, bus.m_ready, bus.grf_we});
    end
    idle_inputs();
    #3;
    reset = 1'b1;
    tick();
    bus.p_we = 1'b1; bus.p_a3 = 5'd2;
    bus.m_valid = 1'b1; bus.m_a3 = 5'd10; bus.m_wd = 32'hBEEF_000A; bus.m_pc = 32'h6000;
    got = 1'b0;
    waited = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      bus.p_wd = 32'h300 + 32'(c);
      bus.p_pc = 32'h9000 + 32'(4 * c);
      #1;
      if (bus.m_ready === 1'b1) begin
        got = 1'b1;
        waited = c;
        push_wr(5'd10, 32'hBEEF_000A, 32'h6000);
      end else begin
        push_wr(5'd2, bus.p_wd, bus.p_pc);
      end
      tick();
    end
    n_cmp++;
    if (!got || waited != int'(LIMIT)) begin
      n_bad++;
      $display("FAIL rf_starve_wait: got granted=%0d at cycle %0d, wanted grant at cycle %0d",
               got, waited, LIMIT);
    end
    bus.m_valid = 1'b0;
    push_wr(5'd2, bus.p_wd, bus.p_pc);
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rf_done: got pending=%0d, wanted 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_p_only();
    test_m_only();
    test_contention();
    test_zero();
    test_reset_force();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
